// File: rtl/wallace_final_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wallace_final_adder_pipe
// Brief    : Two-stage carry-lookahead final adder for the Wallace multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module wallace_final_adder_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_row0,
    input  logic [WIDTH-1:0] in_row1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout
);

    localparam int HALF = WIDTH / 2;
    localparam int NGRP = HALF / 4;

    // HALF-bit adder built from 4-bit groups; group P/G drive the inter-group carries.
    function automatic logic [HALF:0] cla_add(
        input logic [HALF-1:0] a,
        input logic [HALF-1:0] b,
        input logic            cin
    );
        logic [HALF-1:0] p;
        logic [HALF-1:0] g;
        logic [HALF-1:0] c;
        logic [NGRP-1:0] gp;
        logic [NGRP-1:0] gg;
        logic [NGRP:0]   gc;
        int              base;
        p     = a ^ b;
        g     = a & b;
        c     = '0;
        gc    = '0;
        gc[0] = cin;
        for (int k = 0; k < NGRP; k++) begin
            base  = 4 * k;
            gp[k] = &p[base +: 4];
            gg[k] = g[base+3]
                  | (p[base+3] & g[base+2])
                  | (p[base+3] & p[base+2] & g[base+1])
                  | (p[base+3] & p[base+2] & p[base+1] & g[base]);
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < NGRP; k++) begin
            base    = 4 * k;
            c[base] = gc[k];
            for (int i = 1; i < 4; i++) begin
                c[base+i] = g[base+i-1] | (p[base+i-1] & c[base+i-1]);
            end
        end
        return {gc[NGRP], p ^ c};
    endfunction

    logic            s1_valid;
    logic [HALF-1:0] s1_sum_lo;
    logic            s1_c_mid;
    logic [HALF-1:0] s1_hi0;
    logic [HALF-1:0] s1_hi1;
    logic            s2_valid;

    logic            s2_take;
    logic            accept;
    logic [HALF:0]   lo_add;
    logic [HALF:0]   hi_add;

    assign lo_add    = cla_add(in_row0[HALF-1:0], in_row1[HALF-1:0], 1'b0);
    assign hi_add    = cla_add(s1_hi0, s1_hi1, s1_c_mid);

    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign s2_take   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_take;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sum_lo  <= '0;
            s1_c_mid   <= 1'b0;
            s1_hi0     <= '0;
            s1_hi1     <= '0;
        end else begin
            if (accept) begin
                s1_valid  <= 1'b1;
                s1_sum_lo <= lo_add[HALF-1:0];
                s1_c_mid  <= lo_add[HALF];
                s1_hi0    <= in_row0[WIDTH-1:HALF];
                s1_hi1    <= in_row1[WIDTH-1:HALF];
            end else if (s2_take) begin
                s1_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_cout   <= 1'b0;
        end else begin
            if (s2_take) begin
                s2_valid   <= 1'b1;
                out_result <= {hi_add[HALF-1:0], s1_sum_lo};
                out_cout   <= hi_add[HALF];
            end else if (out_ready) begin
                s2_valid   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wallace_final_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_wallace_final_adder_pipe
// Brief    : Self-checking bench with a queue-based sum model for the final adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wallace_final_adder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_row0 = '0;
    logic [31:0] in_row1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_cout;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [32:0] v;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [32:0] out_log[$];
    logic        hold_prev = 1'b0;
    logic [32:0] hold_val  = '0;

    wallace_final_adder_pipe #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row0    (in_row0),
        .in_row1    (in_row1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Compare process: pipeline occupancy and ordering derived from the accept queue.
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
            chk("reset_out_data", {31'd0, out_cout, out_result}, 64'd0);
            q.delete();
            hold_prev = 1'b0;
        end else begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2) || out_ready});
            chk("out_valid", {63'd0, out_valid},
                {63'd0, (q.size() > 0) && (cyc >= q[0].acc + 2)});
            if (out_valid && q.size() > 0)
                chk("out_data", {31'd0, out_cout, out_result}, {31'd0, q[0].v});
            if (hold_prev)
                chk("stall_hold", {30'd0, out_valid, out_cout, out_result}, {30'd0, 1'b1, hold_val});
            hold_prev = out_valid && !out_ready;
            hold_val  = {out_cout, out_result};
            if (out_valid && out_ready) begin
                out_log.push_back({out_cout, out_result});
                if (q.size() > 0) void'(q.pop_front());
            end
            if (in_valid && in_ready)
                q.push_back('{v: model(in_row0, in_row1), acc: cyc});
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit done = 0;
        in_valid = 1'b1;
        in_row0  = a;
        in_row1  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            fails++;
            $display("FAIL send_timeout: in_ready never seen for %h+%h", a, b);
        end
        in_valid = 1'b0;
        in_row0  = $urandom;
        in_row1  = $urandom;
    endtask

    task automatic wait_log(input int target);
        for (int i = 0; i < 60 && out_log.size() < target; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (out_log.size() < target) begin
            fails++;
            $display("FAIL output_timeout: got %0d results expected %0d", out_log.size(), target);
        end
    endtask

    task automatic direct(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [32:0] exp);
        int n = out_log.size();
        send(a, b);
        wait_log(n + 1);
        if (out_log.size() > n) chk(name, {31'd0, out_log[n]}, {31'd0, exp});
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc;
        int n;
        int got;
        logic [31:0] a;
        logic [31:0] b;

        chk("model_pin_ovf", {31'd0, model(32'hFFFF_FFFF, 32'h1)}, {31'd0, 33'h1_0000_0000});
        chk("model_pin_msb", {31'd0, model(32'h8000_0000, 32'h8000_0000)}, {31'd0, 33'h1_0000_0000});
        chk("model_pin_mul", {31'd0, model(32'hFFFE_0000, 32'h1)}, {31'd0, 33'h0_FFFE_0001});

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_reset_out", {31'd0, out_valid, out_cout, out_result}, 64'd0);

        // Boundary-crossing carry, overflow and multiplier-shaped rows.
        direct("carry_mid", 32'h0000_FFFF, 32'h0000_0001, 33'h0_0001_0000);
        direct("ovf_all_ones", 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
        direct("ovf_msb", 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000);
        direct("mul_ffff", 32'hFFFE_0000, 32'h0000_0001, 33'h0_FFFE_0001);

        // Back-to-back stream at full throughput.
        n = out_log.size();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_row0  = i * 32'h0101_0101;
            in_row1  = 32'h00FF_00FF;
            @(negedge clk);
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_log(n + 8);
        for (int i = 0; i < 8; i++)
            if (out_log.size() > n + i)
                chk("stream_sum", {31'd0, out_log[n+i]},
                    {31'd0, model(i * 32'h0101_0101, 32'h00FF_00FF)});

        // Backpressure: two accepts fill the pipe, then in_ready must drop.
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_row0 = (acc == 0) ? 32'h1234_5678 : (acc == 1) ? 32'h0100_0000 : 32'hDEAD_BEEF;
            in_row1 = (acc == 0) ? 32'h1111_1111 : (acc == 1) ? 32'h00FF_FFFF : 32'h0000_0001;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        chk("bp_accepts", acc, 2);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_frozen", {31'd0, out_valid, out_cout, out_result}, {31'd0, 1'b1, 33'h0_2345_6789});
        n = out_log.size();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        wait_log(n + 2);
        if (out_log.size() > n + 1) begin
            chk("bp_first", {31'd0, out_log[n]}, {31'd0, 33'h0_2345_6789});
            chk("bp_second", {31'd0, out_log[n+1]}, {31'd0, 33'h0_01FF_FFFF});
        end

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        send(32'hAAAA_0000, 32'h0000_5555);
        send(32'h0F0F_0F0F, 32'h0101_0101);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_out", {31'd0, out_valid, out_cout, out_result}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        n = out_log.size();
        direct("after_reset", 32'h0000_0003, 32'h0000_0004, 33'h0_0000_0007);
        chk("no_ghost_results", out_log.size(), n + 1);

        // Randomised traffic with random backpressure.
        got = 0;
        for (int i = 0; i < 40000 && got < 10000; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFFF;
            if ($urandom_range(0, 15) == 0) b = 32'h0000_FFFF;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_row0   = a;
            in_row1   = b;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) got++;
            @(posedge clk);
            #1;
        end
        chk("random_accepts", got, 10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
